// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp: multi-port register file with a post-reset clear engine and a debug tap
// Revision: 1.0
// ============================================================================
module regfile_mp #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1,
  parameter int DEBUG_REG     = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  input  logic                              we0,
  input  logic                              we1,
  input  logic [ADDRESS_WIDTH-1:0]          wa0,
  input  logic [ADDRESS_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]             wd0,
  input  logic [DATA_WIDTH-1:0]             wd1,
  output logic [DATA_WIDTH-1:0]             dbg_data,
  output logic                              init_busy
);

  localparam int                     c_DEPTH   = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] c_LAST    = '1;
  localparam logic [ADDRESS_WIDTH-1:0] c_DBG_IDX = ADDRESS_WIDTH'(DEBUG_REG);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]    r_regs [c_DEPTH];

  logic w_busy;
  logic w_wr0;
  logic w_wr1;

  // rst is included directly so reads are masked in the very cycle reset is asserted
  assign w_busy    = rst || (r_state == ST_CLEAR);
  assign init_busy = w_busy;
  assign w_wr0     = (r_state == ST_READY) && we0 && (wa0 != '0);
  assign w_wr1     = (r_state == ST_READY) && we1 && (wa1 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_regs[r_cnt] <= '0;
      r_cnt         <= r_cnt + 1'b1;
      if (r_cnt == c_LAST) begin
        r_state <= ST_READY;
      end
    end else begin
      if (w_wr0) begin
        r_regs[wa0] <= wd0;
      end
      // port 1 is assigned last so it wins on an address collision
      if (w_wr1) begin
        r_regs[wa1] <= wd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0]    w_rd;

    assign w_ra = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      w_rd = r_regs[w_ra];
      if (w_busy || (w_ra == '0)) begin
        w_rd = '0;
      end else if (BYPASS != 0) begin
        if (we1 && (wa1 == w_ra)) begin
          w_rd = wd1;
        end else if (we0 && (wa0 == w_ra)) begin
          w_rd = wd0;
        end
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_rd;
  end

  if (DEBUG_REG == 0) begin : g_dbg_zero
    assign dbg_data = '0;
  end else begin : g_dbg_reg
    assign dbg_data = w_busy ? '0 : r_regs[c_DBG_IDX];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp: vector table, clear-timing sequences and random traffic vs. a model
// Revision: 1.0
// ============================================================================
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [31:0] dbg_data, dbg_data_nb;
  logic        init_busy, init_busy_nb;

  int total = 0;
  int bad   = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .dbg_data(dbg_data), .init_busy(init_busy)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .dbg_data(dbg_data_nb), .init_busy(init_busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: architectural contents plus number of clear cycles still outstanding
  logic [31:0] mdl [32];
  int          busy_left = 32;

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || busy_left > 0 || a == 5'd0) return 32'd0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mdl[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        eb;
    logic [31:0] ed;
    eb = rst || (busy_left > 0);
    ed = eb ? 32'd0 : mdl[10];
    for (int i = 0; i < 2; i++) begin
      cmp({tag, "_rd_byp"}, rd_data[i*32 +: 32],    exp_rd(rd_addr[i*5 +: 5], 1'b1));
      cmp({tag, "_rd_nb"},  rd_data_nb[i*32 +: 32], exp_rd(rd_addr[i*5 +: 5], 1'b0));
    end
    cmp({tag, "_busy"},    {31'd0, init_busy},    {31'd0, eb});
    cmp({tag, "_busy_nb"}, {31'd0, init_busy_nb}, {31'd0, eb});
    cmp({tag, "_dbg"},     dbg_data,    ed);
    cmp({tag, "_dbg_nb"},  dbg_data_nb, ed);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      busy_left = 32;
      for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we0 && wa0 != 5'd0) mdl[wa0] = wd0;
      if (we1 && wa1 != 5'd0) mdl[wa1] = wd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    #1;
    while (init_busy && n < 100) begin
      check_all(name);
      step();
      #1;
      n++;
    end
    cmp({name, "_len"}, n, 32);
  endtask

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e0;  logic [31:0] e1; logic [31:0] edbg;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
    vt[1]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
    vt[2]  = '{1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    vt[3]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vt[4]  = '{1, 5'd10, 32'h11,       1, 5'd10, 32'h22, 5'd10, 5'd10, 32'h22,      32'h22,       32'h0};
    vt[5]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd10, 5'd5,  32'h22,       32'hDEADBEEF, 32'h22};
    vt[6]  = '{0, 5'd0,  32'h0,        1, 5'd7, 32'h1,  5'd7,  5'd10, 32'h1,        32'h22,       32'h22};
    vt[7]  = '{1, 5'd7,  32'h55,       0, 5'd0, 32'h0,  5'd7,  5'd7,  32'h55,       32'h55,       32'h22};
    vt[8]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd7,  5'd3,  32'h55,       32'h0,        32'h22};
    vt[9]  = '{1, 5'd10, 32'hA5,       1, 5'd3, 32'h33, 5'd10, 5'd3,  32'hA5,       32'h33,       32'h22};
    vt[10] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,  5'd10, 5'd3,  32'hA5,       32'h33,       32'hA5};

    rst = 1'b1;
    rd_addr = '0;
    idle_inputs();
    for (int k = 0; k < 32; k++) mdl[k] = 32'd0;

    // reset held three cycles, then clear must last exactly 32 cycles
    #1;
    for (int c = 0; c < 3; c++) begin
      #1; check_all("rst"); step();
    end
    rst = 1'b0;
    count_busy("clear");

    for (int v = 0; v < 11; v++) begin
      we0 = vt[v].we0; wa0 = vt[v].wa0; wd0 = vt[v].wd0;
      we1 = vt[v].we1; wa1 = vt[v].wa1; wd1 = vt[v].wd1;
      rd_addr = {vt[v].ra1, vt[v].ra0};
      #1;
      cmp("vec_rd0", rd_data[31:0],  vt[v].e0);
      cmp("vec_rd1", rd_data[63:32], vt[v].e1);
      cmp("vec_dbg", dbg_data,       vt[v].edbg);
      check_all("vec");
      step();
    end

    // no-bypass DUT: same-cycle old value, new value after the edge
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h77; rd_addr = {5'd7, 5'd7};
    #1;
    cmp("nb_same_cycle", rd_data_nb[31:0], 32'h55);
    cmp("byp_same_cycle", rd_data[31:0], 32'h77);
    step();
    idle_inputs();
    #1;
    cmp("nb_next_cycle", rd_data_nb[31:0], 32'h77);

    // reset during clear, with port-1 writes that must be dropped
    rst = 1'b1; #1; check_all("rst2"); step();
    rst = 1'b0;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h99; rd_addr = {5'd3, 5'd10};
    for (int c = 0; c < 12; c++) begin
      #1; check_all("midclr"); step();
    end
    rst = 1'b1; #1; check_all("rst3"); step();
    rst = 1'b0;
    count_busy("reclear");
    idle_inputs();
    rd_addr = {5'd10, 5'd3};
    #1;
    cmp("reg3_after_clear", rd_data[31:0], 32'h0);
    cmp("reg10_after_clear", rd_data[63:32], 32'h0);
    check_all("post");
    step();

    // random traffic, collision-heavy address range, occasional reset
    for (int r = 0; r < 600; r++) begin
      rst = ($urandom_range(0, 149) == 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      wa0 = 5'($urandom_range(0, 11));
      wa1 = 5'($urandom_range(0, 11));
      wd0 = $urandom;
      wd1 = $urandom;
      rd_addr = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 31))};
      #1;
      check_all("rand");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, the successor to the single-write, two-read register file in the CPU datapath. It provides NUM_READ asynchronous read ports, two synchronous write ports with fixed priority, and optional same-cycle write-to-read bypass. A sequential clear engine zeroes every register after reset. A debug tap exposes one architectural register (a0 by default) to the testbench.

## Interface
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value
- DEBUG_REG, 10, index driven on dbg_data

Reset is synchronous and active-high on `rst`, with one clock, `clk`.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rd_addr  in  NUM_READ*ADDRESS_WIDTH  packed read addresses; port i = slice i
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data; port i = slice i
- we0, we1  in  1  write enables
- wa0, wa1  in  ADDRESS_WIDTH  write addresses
- wd0, wd1  in  DATA_WIDTH  write data
- dbg_data  out  DATA_WIDTH  regs[DEBUG_REG], combinational
- init_busy  out  1  high while reset or clearing is in progress

## Operation
- States: CLEAR, READY. Clear counter `cnt` is ADDRESS_WIDTH bits wide.
- When rst is sampled high: state <= CLEAR, cnt <= 0. No register is written that cycle.
- In CLEAR with rst low, each cycle:
  - regs[cnt] <= 0, cnt <= cnt+1.
  - When cnt == 2**ADDRESS_WIDTH-1, state <= READY and cnt wraps to 0.
- In CLEAR, we0/we1 are ignored and their writes are dropped, not queued.
- In READY, port 0 writes when we0 && wa0 != 0, and port 1 writes when we1 && wa1 != 0.
- Both ports enabled with the same non-zero address: port 1 wins and port 0's data is discarded.
- Register 0 is never written and always reads 0.
- Reads are combinational. While init_busy = 1, all rd_data slices = 0.
- With BYPASS=1, rd_data[i] takes the first match from this list:
  1. rd_addr[i] == 0 → 0
  2. we1 && wa1 == rd_addr[i] → wd1
  3. we0 && wa0 == rd_addr[i] → wd0
  4. otherwise → regs[rd_addr[i]]
- With BYPASS=0, rd_data[i] = regs[rd_addr[i]]. A write is visible from the cycle after the edge.
- dbg_data is never bypassed and is 0 while init_busy = 1. DEBUG_REG = 0 → dbg_data is constant 0.

## Timing
- Reset values: init_busy = 1, rd_data = 0, dbg_data = 0.
- init_busy = 1 in every cycle where rst = 1 or state = CLEAR.
- init_busy falls exactly 2**ADDRESS_WIDTH cycles after the first edge with rst low (32 cycles at the default).
- Reset during CLEAR or READY restarts the clear from cnt = 0. A partially cleared file is never exposed.
- Write latency is 1 edge; read latency is 0 (combinational).
- Bypass path: combinational from we/wa/wd to rd_data.
- The clear writes and the user writes never coincide, because user writes are gated by state.

## Test plan
- Reset clear: hold rst 3 cycles, then release.
  - init_busy stays high for exactly 32 cycles after release.
  - Afterwards all 32 registers read 0, including values written before reset.
- Basic write/read: we0=1, wa0=5, wd0=0xDEADBEEF for 1 cycle.
  - Next cycle, rd_addr port0 = 5 → 0xDEADBEEF; port1 = 0 → 0.
- x0 protection: we0=1, wa0=0, wd0=0xFFFFFFFF.
  - Reading address 0 → 0, both in the same cycle (BYPASS=1) and the next cycle.
- Dual-write collision: we0=we1=1, wa0=wa1=10, wd0=0x11, wd1=0x22.
  - Next cycle, rd_data = 0x22 and dbg_data = 0x22.
- Bypass, with reg 7 = 0x1 and then we0=1, wa0=7, wd0=0x55 while reading 7:
  - BYPASS=1 → same-cycle rd_data = 0x55.
  - BYPASS=0 → same-cycle rd_data = 0x1, then 0x55 the next cycle; dbg_data is unaffected.
- Reset mid-clear: assert rst at clear cycle 12, then release.
  - init_busy stays high a further full 32 cycles.
  - we1 writes issued during CLEAR (wa1=3, wd1=0x99) leave reg 3 = 0.
